// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the fetch stage's instruction-ROM port, the
// controller/hazard inputs and the IF/ID outputs towards decode.
// master = fetch stage side, slave = ROM/controller/decode side.
// Optional FETCH_STATS_EN adds fetch_count/redirect_count.
interface fetch_unit_if #(
  parameter int IMEM_AW = 10
);
  // instruction ROM
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  // hazard unit and controller
  logic        stall;
  logic        beq;
  logic        bne;
  logic        jmp;
  logic        jal;
  logic        jr;
  logic        syscall;
  logic        rs_equal;
  logic [31:0] rs_data;
  // fetch state and IF/ID register
  logic [31:0] pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic [5:0]  op;
  logic [5:0]  func;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm16;
  logic        redirect;
  logic        halted;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count;
  logic [31:0] redirect_count;
`endif

  modport master (
    output imem_addr, pc, id_valid, id_instr, id_pc_plus4,
           op, func, rs, rt, rd, shamt, imm16, redirect, halted,
`ifdef FETCH_STATS_EN
           fetch_count, redirect_count,
`endif
    input  imem_rdata, stall, beq, bne, jmp, jal, jr, syscall,
           rs_equal, rs_data
  );

  modport slave (
    input  imem_addr, pc, id_valid, id_instr, id_pc_plus4,
           op, func, rs, rt, rd, shamt, imm16, redirect, halted,
`ifdef FETCH_STATS_EN
           fetch_count, redirect_count,
`endif
    output imem_rdata, stall, beq, bne, jmp, jal, jr, syscall,
           rs_equal, rs_data
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS instruction fetch + IF/ID register; resolves ID-stage
// branches/jumps (one bubble per taken redirect), stall hold, syscall halt.
// Ports: clk, rst_n (async active-low), bus (fetch_unit_if.master): ROM
// address/data, controller flow inputs, pc, IF/ID fields, redirect, halted.
// Optional macro FETCH_STATS_EN adds saturating fetch/redirect counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  // What the next clock edge does to the fetch state.
  typedef enum logic [1:0] {
    ACT_HOLD,   // halted or stalled
    ACT_HALT,   // syscall reached ID
    ACT_REDIR,  // taken branch/jump: load target, squash wrong path
    ACT_LOAD    // sequential fetch
  } act_e;

  logic [31:0] pc_q;
  logic [31:0] id_instr_q;
  logic [31:0] id_pc4_q;
  logic        id_valid_q;
  logic        halted_q;

  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [31:0] target;
  logic        taken;
  logic        redirect;
  act_e        act;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    taken  = 1'b0;
    br_off = '0;
    target = '0;
    // Control inputs only mean something when ID holds a real instruction.
    taken = id_valid_q & ((bus.beq & bus.rs_equal) | (bus.bne & ~bus.rs_equal) |
                          bus.jmp | bus.jal | bus.jr);
    redirect = taken & ~bus.stall & ~halted_q;
    br_off = {{14{id_instr_q[15]}}, id_instr_q[15:0], 2'b00};
    if (bus.jr)
      target = bus.rs_data;
    else if (bus.jmp | bus.jal)
      target = {id_pc4_q[31:28], id_instr_q[25:0], 2'b00};
    else
      target = id_pc4_q + br_off;
  end

  always_comb begin
    act = ACT_LOAD;
    if (halted_q || bus.stall)
      act = ACT_HOLD;   // stall defers redirect/syscall to a later cycle
    else if (id_valid_q && bus.syscall)
      act = ACT_HALT;
    else if (redirect)
      act = ACT_REDIR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      id_instr_q <= '0;
      id_pc4_q   <= '0;
      id_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      case (act)
        ACT_HALT: begin
          halted_q   <= 1'b1;
          id_valid_q <= 1'b0;
          id_instr_q <= '0;
        end
        ACT_REDIR: begin
          pc_q       <= target;
          id_valid_q <= 1'b0;
          id_instr_q <= '0;
        end
        ACT_LOAD: begin
          pc_q       <= pc_plus4;
          id_instr_q <= bus.imem_rdata;
          id_pc4_q   <= pc_plus4;
          id_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] redir_cnt_q;

  // Both counters stop naturally while halted: no loads and no redirects
  // can occur once halted_q is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      if (act == ACT_LOAD && fetch_cnt_q != 32'hFFFF_FFFF)
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (redirect && redir_cnt_q != 32'hFFFF_FFFF)
        redir_cnt_q <= redir_cnt_q + 32'd1;
    end
  end

  assign bus.fetch_count    = fetch_cnt_q;
  assign bus.redirect_count = redir_cnt_q;
`endif

  assign bus.imem_addr   = pc_q[IMEM_AW+1:2];
  assign bus.pc          = pc_q;
  assign bus.id_valid    = id_valid_q;
  assign bus.id_instr    = id_instr_q;
  assign bus.id_pc_plus4 = id_pc4_q;
  assign bus.op          = id_instr_q[31:26];
  assign bus.func        = id_instr_q[5:0];
  assign bus.rs          = id_instr_q[25:21];
  assign bus.rt          = id_instr_q[20:16];
  assign bus.rd          = id_instr_q[15:11];
  assign bus.shamt       = id_instr_q[10:6];
  assign bus.imm16       = id_instr_q[15:0];
  assign bus.redirect    = redirect;
  assign bus.halted      = halted_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS core. It feeds the instruction-decode controller: it produces the op/func fields and the other instruction fields. It consumes the controller's flow-control outputs (beq, bne, jmp, jal, jr, syscall) and closes the loop by computing and applying the next PC. Branch and jump resolution happens in ID, with a one-bubble penalty on every taken redirect.

Parameters:
RESET_PC, 32'h0000_0000, byte address loaded into PC on reset
IMEM_AW, 10, word-address width of instruction memory

Ports:
clk  in  1  core clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
imem_addr  out  IMEM_AW  word address to instruction ROM, equal to pc[IMEM_AW+1:2]
imem_rdata  in  32  instruction word; combinational read of imem_addr
stall  in  1  hazard hold from the hazard unit; PC and IF/ID hold
beq  in  1  from controller
bne  in  1  from controller
jmp  in  1  from controller
jal  in  1  from controller
jr  in  1  from controller
syscall  in  1  from controller; halt request
rs_equal  in  1  rs_data == rt_data, computed in ID
rs_data  in  32  forwarded rs value, used as jr target
pc  out  32  current fetch PC
id_valid  out  1  IF/ID holds a real instruction
id_instr  out  32  IF/ID instruction (32'h0 when bubble)
id_pc_plus4  out  32  PC+4 of the ID instruction; link value for jal
op  out  6  id_instr[31:26]
func  out  6  id_instr[5:0]
rs, rt, rd  out  5 each  id_instr[25:21], [20:16], [15:11]
shamt  out  5  id_instr[10:6]
imm16  out  16  id_instr[15:0]
redirect  out  1  a redirect is applied this cycle
halted  out  1  fetch stopped by syscall

Behaviour:
- Reset (async, rst_n=0) sets: pc=RESET_PC, id_valid=0, id_instr=0, id_pc_plus4=0, halted=0, redirect=0. Release is taken at the next clk edge.
- Field outputs (op, func, rs, rt, rd, shamt, imm16) are pure slices of registered id_instr, so there is zero added latency to the decoder.
- Control inputs take effect only when id_valid=1; when id_valid=0 they are ignored.
- taken = id_valid & ((beq & rs_equal) | (bne & ~rs_equal) | jmp | jal | jr).
- redirect = taken & ~stall & ~halted (combinational).
- Target selection, priority jr > (jmp|jal) > branch:
  - jr: rs_data (no alignment check).
  - jmp/jal: {id_pc_plus4[31:28], id_instr[25:0], 2'b00}.
  - branch: id_pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00}, modulo 2^32.
- Sequential PC: pc+4 modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is allowed.
- Each edge, in priority order:
  1. halted=1: hold all state; id_valid=0.
  2. stall=1: hold pc, id_instr, id_pc_plus4, id_valid unchanged. Redirect and syscall are deferred and re-evaluated next cycle.
  3. id_valid & syscall: halted<=1, pc held, IF/ID <= bubble (id_valid=0, id_instr=0).
  4. redirect: pc<=target, IF/ID <= bubble, so the wrong-path instruction is squashed.
  5. Otherwise: pc<=pc+4, id_instr<=imem_rdata, id_pc_plus4<=pc+4, id_valid<=1.
- A taken redirect costs exactly one bubble cycle. Not-taken branches cost nothing.
- halted is sticky; only rst_n clears it.
- Reset asserted mid-stall or mid-redirect: state returns to reset values immediately, regardless of clk.

Optional Feature:
FETCH_STATS_EN. When defined, adds two outputs:
- fetch_count (32): increments on every case-5 load.
- redirect_count (32): increments on every cycle with redirect=1.
Both reset to 0, saturate at 32'hFFFF_FFFF, and freeze while halted.
When undefined, neither port nor counter exists and behaviour is otherwise identical.

Test Plan:
1. Reset release, ROM = sequential ADDs, no stall -> pc 0,4,8,C on successive edges; id_valid=1 from 2nd edge; id_instr tracks ROM[n-1].
2. beq at 0x8 with imm16=16'hFFFE, rs_equal=1 -> redirect=1 in ID; next pc=0x0C+(-8)=0x4; one bubble (id_valid=0) then ROM[1].
3. Same beq with rs_equal=0 -> no redirect, pc continues 0x10, no bubble.
4. jal at 0x0000_0010 with target26=26'h40 -> pc=0x100; id_pc_plus4 during jal = 0x14. jr with rs_data=0x14 -> pc=0x14.
5. stall=1 for 3 cycles while a taken bne sits in ID -> pc and id_instr frozen, redirect=0; on stall release redirect=1 and target is applied once.
6. syscall in ID -> halted=1 next edge, pc frozen, id_valid=0 for 10 cycles; pulse rst_n low asynchronously mid-cycle -> pc=RESET_PC and halted=0 immediately.
